// File: rtl/tt_extractor_if.sv
// Nibble stream between the truth-table extractor and its consumer.
// The master drives valid and data. The slave drives ready.
interface tt_extractor_if;
   logic       nib_valid;
   logic [3:0] nib_data;
   logic       nib_ready;

   modport master (
      output nib_valid,
      output nib_data,
      input  nib_ready
   );

   modport slave (
      input  nib_valid,
      input  nib_data,
      output nib_ready
   );
endinterface

// File: rtl/tt_extractor.sv
// Sequential truth-table extractor for a single-output N_IN-input function.
// The block sweeps every input vector and holds each one SETTLE+1 cycles.
// It samples f_in at the last edge of each hold window, then streams the
// table MSB nibble first.
module tt_extractor #(
   parameter int unsigned N_IN   = 7,
   parameter int unsigned SETTLE = 1
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   output logic [N_IN-1:0]        x_out,
   input  logic                   f_in,
   output logic                   busy,
   output logic [(2**N_IN)-1:0]   tt,
   output logic [7:0]             weight,
   output logic                   done,
   tt_extractor_if.master         nib
);

   localparam int unsigned TT_W = 2 ** N_IN;
   localparam int unsigned N_NIB = TT_W / 4;
   localparam int unsigned KW = $clog2(N_NIB);

   localparam logic [N_IN-1:0] IDX_MAX = '1;
   localparam logic [N_IN-1:0] IDX_ONE = {{(N_IN-1){1'b0}}, 1'b1};
   localparam logic [KW-1:0]   K_MAX   = '1;
   localparam logic [KW-1:0]   K_ONE   = {{(KW-1){1'b0}}, 1'b1};
   localparam logic [3:0]      SETTLE_C = 4'(SETTLE);

   typedef enum logic [1:0] {
      StIdle,
      StSweep,
      StStream
   } state_e;

   state_e            state_q, state_d;
   logic [N_IN-1:0]   idx_q, idx_d;
   logic [N_IN-1:0]   x_q, x_d;
   logic [3:0]        wcnt_q, wcnt_d;
   logic [KW-1:0]     k_q, k_d;
   logic [TT_W-1:0]   tt_q, tt_d;
   logic [7:0]        weight_q, weight_d;
   logic              busy_q, busy_d;
   logic              valid_q, valid_d;
   logic              done_q, done_d;
   logic [N_IN-1:0]   nib_base;

   // State register. An asynchronous reset abandons any sweep or stream in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         idx_q    <= '0;
         x_q      <= '0;
         wcnt_q   <= '0;
         k_q      <= '0;
         tt_q     <= '0;
         weight_q <= '0;
         busy_q   <= 1'b0;
         valid_q  <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         idx_q    <= idx_d;
         x_q      <= x_d;
         wcnt_q   <= wcnt_d;
         k_q      <= k_d;
         tt_q     <= tt_d;
         weight_q <= weight_d;
         busy_q   <= busy_d;
         valid_q  <= valid_d;
         done_q   <= done_d;
      end
   end

   // Next-state logic for the sweep and stream phases.
   always_comb begin
      state_d  = state_q;
      idx_d    = idx_q;
      x_d      = x_q;
      wcnt_d   = wcnt_q;
      k_d      = k_q;
      tt_d     = tt_q;
      weight_d = weight_q;
      busy_d   = busy_q;
      valid_d  = valid_q;
      done_d   = 1'b0;

      case (state_q)
         StIdle: begin
            if (start) begin
               tt_d     = '0;
               weight_d = '0;
               idx_d    = '0;
               x_d      = '0;
               wcnt_d   = '0;
               k_d      = '0;
               busy_d   = 1'b1;
               state_d  = StSweep;
            end
         end

         StSweep: begin
            if (wcnt_q == SETTLE_C) begin
               tt_d[idx_q] = f_in;
               weight_d    = weight_q + {7'd0, f_in};
               wcnt_d      = '0;
               if (idx_q == IDX_MAX) begin
                  // x_out keeps the last vector. The stream starts on the next cycle.
                  k_d     = '0;
                  valid_d = 1'b1;
                  state_d = StStream;
               end else begin
                  idx_d = idx_q + IDX_ONE;
                  x_d   = idx_q + IDX_ONE;
               end
            end else begin
               wcnt_d = wcnt_q + 4'd1;
            end
         end

         StStream: begin
            if (valid_q && nib.nib_ready) begin
               if (k_q == K_MAX) begin
                  valid_d = 1'b0;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
                  k_d     = '0;
                  state_d = StIdle;
               end else begin
                  k_d = k_q + K_ONE;
               end
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Top bit of the current nibble. Nibble k covers tt[TT_W-1-4k -: 4].
   always_comb begin
      nib_base = IDX_MAX - {k_q, 2'b00};
   end

   assign x_out         = x_q;
   assign busy          = busy_q;
   assign tt            = tt_q;
   assign weight        = weight_q;
   assign done          = done_q;
   assign nib.nib_valid = valid_q;
   // k and tt only change on an accept, so the data stays stable during a stall.
   assign nib.nib_data  = valid_q ? tt_q[nib_base -: 4] : 4'h0;

endmodule

// File: tb/tb_tt_extractor.sv
// Self-checking bench for tt_extractor.
// A scoreboard queue holds the expected nibbles. They are pushed when a run
// starts and popped as the DUT hands nibbles over.
module tb_tt_extractor;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [6:0]   x_out;
   logic         f_in;
   logic         busy;
   logic [127:0] tt;
   logic [7:0]   weight;
   logic         done;

   // Second instance with SETTLE=0 for the single-cycle sweep case.
   logic         start_z;
   logic [6:0]   x_out_z;
   logic         f_in_z;
   logic         busy_z;
   logic [127:0] tt_z;
   logic [7:0]   weight_z;
   logic         done_z;

   tt_extractor_if nib1 ();
   tt_extractor_if nib0 ();

   int           n_checks = 0;
   int           n_fail = 0;
   int           fn_sel = 0;
   logic [127:0] lut;
   logic [3:0]   sb_q[$];
   int           popped = 0;
   bit           stalled = 1'b0;
   logic [3:0]   held = 4'h0;

   always #5 clk = ~clk;

   tt_extractor #(.N_IN(7), .SETTLE(1)) dut (
      .clk    (clk),
      .rst    (rst),
      .start  (start),
      .x_out  (x_out),
      .f_in   (f_in),
      .busy   (busy),
      .tt     (tt),
      .weight (weight),
      .done   (done),
      .nib    (nib1)
   );

   tt_extractor #(.N_IN(7), .SETTLE(0)) dut_z (
      .clk    (clk),
      .rst    (rst),
      .start  (start_z),
      .x_out  (x_out_z),
      .f_in   (f_in_z),
      .busy   (busy_z),
      .tt     (tt_z),
      .weight (weight_z),
      .done   (done_z),
      .nib    (nib0)
   );

   function automatic logic fn_eval(input int sel, input logic [6:0] x);
      case (sel)
         0:       return 1'b0;
         1:       return x[0];
         2:       return x[6];
         3:       return 1'b1;
         default: return lut[x];
      endcase
   endfunction

   function automatic logic maj3(input logic [6:0] x);
      return (x[0] & x[1]) | (x[0] & x[5]) | (x[1] & x[5]);
   endfunction

   assign f_in   = fn_eval(fn_sel, x_out);
   assign f_in_z = maj3(x_out_z);

   task automatic check_eq(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Scoreboard monitor. It samples on the falling edge, before the accepting rising edge.
   always @(negedge clk) begin
      logic [3:0] exp_nib;
      if (stalled && nib1.nib_valid) check_eq("stall_hold", nib1.nib_data, held);
      if (nib1.nib_valid && nib1.nib_ready) begin
         if (sb_q.size() == 0) begin
            check_eq("sb_underflow", sb_q.size(), 1);
         end else begin
            exp_nib = sb_q.pop_front();
            check_eq("nibble", nib1.nib_data, exp_nib);
         end
         popped++;
      end
      stalled = nib1.nib_valid && !nib1.nib_ready;
      held    = nib1.nib_data;
   end

   task automatic run_case(input int sel, input bit rand_ready, input bit mid_start,
                           input bit check_time);
      logic [127:0] exp_tt;
      logic [3:0]   nb;
      int           exp_w;
      int           busy_cnt;
      bit           got_done;
      bit           sent;
      fn_sel = sel;
      exp_w  = 0;
      for (int i = 0; i < 128; i++) begin
         exp_tt[i] = fn_eval(sel, 7'(i));
         exp_w += int'(exp_tt[i]);
      end
      for (int j = 0; j < 32; j++) begin
         for (int b = 0; b < 4; b++) nb[3-b] = exp_tt[127 - 4*j - b];
         sb_q.push_back(nb);
      end
      popped   = 0;
      busy_cnt = 0;
      got_done = 1'b0;
      sent     = 1'b0;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      if (busy) busy_cnt++;
      for (int c = 0; c < 3000; c++) begin
         @(posedge clk); #1;
         if (done) begin
            got_done = 1'b1;
            break;
         end
         if (busy) busy_cnt++;
         nib1.nib_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         start = 1'b0;
         if (mid_start && !sent && popped >= 10) begin
            start = 1'b1;
            sent  = 1'b1;
         end
      end
      start = 1'b0;
      check_eq("done_seen", got_done, 1);
      check_eq("tt", tt, exp_tt);
      check_eq("weight", weight, exp_w);
      check_eq("nib_count", popped, 32);
      check_eq("sb_empty", sb_q.size(), 0);
      check_eq("x_out_hold", x_out, 127);
      check_eq("valid_low", nib1.nib_valid, 0);
      if (check_time) check_eq("busy_cycles", busy_cnt, 288);
      @(posedge clk); #1;
      check_eq("done_pulse", done, 0);
      check_eq("idle_busy", busy, 0);
      nib1.nib_ready = 1'b1;
   endtask

   initial begin
      int   sweep_cnt;
      bit   hit;
      lut            = {$urandom, $urandom, $urandom, $urandom};
      rst            = 1'b1;
      start          = 1'b0;
      start_z        = 1'b0;
      nib1.nib_ready = 1'b1;
      nib0.nib_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_busy", busy, 0);
      check_eq("rst_valid", nib1.nib_valid, 0);
      check_eq("rst_data", nib1.nib_data, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_x", x_out, 0);
      check_eq("rst_tt", tt, 0);
      check_eq("rst_weight", weight, 0);
      rst = 1'b0;

      run_case(0, 1'b0, 1'b0, 1'b1);
      run_case(1, 1'b0, 1'b0, 1'b1);
      check_eq("tt_all_A", tt, {32{4'hA}});
      check_eq("weight_x0", weight, 64);
      run_case(2, 1'b0, 1'b0, 1'b1);
      run_case(3, 1'b0, 1'b0, 1'b1);
      check_eq("weight_full", weight, 128);
      run_case(4, 1'b0, 1'b0, 1'b1);
      run_case(4, 1'b1, 1'b1, 1'b0);

      // Assert reset in the middle of a sweep.
      fn_sel = 4;
      @(posedge clk); #1 start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      for (int c = 0; c < 400; c++) begin
         @(posedge clk); #1;
         if (x_out == 7'd60) break;
      end
      check_eq("reach_idx60", x_out, 60);
      rst = 1'b1;
      #1;
      check_eq("mid_rst_x", x_out, 0);
      check_eq("mid_rst_tt", tt, 0);
      check_eq("mid_rst_weight", weight, 0);
      check_eq("mid_rst_busy", busy, 0);
      check_eq("mid_rst_valid", nib1.nib_valid, 0);
      check_eq("mid_rst_data", nib1.nib_data, 0);
      check_eq("mid_rst_done", done, 0);
      sb_q.delete();
      @(posedge clk); #1 rst = 1'b0;
      run_case(4, 1'b0, 1'b0, 1'b1);

      // Majority function with SETTLE=0: one vector per cycle.
      @(posedge clk); #1 start_z = 1'b1;
      @(posedge clk); #1 start_z = 1'b0;
      sweep_cnt = 0;
      for (int c = 0; c < 500; c++) begin
         @(posedge clk); #1;
         sweep_cnt++;
         if (nib0.nib_valid) break;
      end
      check_eq("z_sweep_cycles", sweep_cnt, 128);
      hit = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(posedge clk); #1;
         if (done_z) begin
            hit = 1'b1;
            break;
         end
      end
      check_eq("z_done_seen", hit, 1);
      check_eq("z_weight", weight_z, 64);
      check_eq("z_tt7", tt_z[7], 1);
      check_eq("z_tt3", tt_z[3], 1);
      check_eq("z_tt1", tt_z[1], 0);
      begin
         logic [127:0] exp_z;
         for (int i = 0; i < 128; i++) exp_z[i] = maj3(7'(i));
         check_eq("z_tt", tt_z, exp_z);
      end
      check_eq("z_busy_end", busy_z, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/tt_extractor.md
Name: tt_extractor

Overview:
- Sequential truth-table extractor for the 7-input classification flow. It is the reading side of a single-output 7-input combinational function block.
- On start, it drives all 128 input assignments onto the function's inputs and samples the function's output for each one. It assembles a 128-bit truth table and a ones-count (weight).
- It then streams the table as 32 hex nibbles, MSB nibble first, over a valid/ready interface. This matches the hex naming of classified functions.

Parameters:
- N_IN, 7, number of function inputs. Fixed at 7; table width is 2**N_IN = 128.
- SETTLE, 1, extra cycles the input vector is held before f_in is sampled. Legal range 0..15.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin extraction. Sampled only in IDLE.
- x_out  output  7  input vector to the function under test. x_out[0] drives x0 … x_out[6] drives x6.
- f_in  input  1  function output, returned combinationally.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- tt  output  128  captured truth table. tt[i] = f(x = i), with x0 as index LSB.
- weight  output  8  number of ones in tt, range 0..128.
- nib_valid  output  1  nibble stream valid.
- nib_data  output  4  current hex nibble.
- nib_ready  input  1  consumer ready.
- done  output  1  one-cycle pulse when the last nibble is accepted.

Behaviour:
- Reset is asynchronous. All of the following go to 0: state (IDLE), x_out, tt, weight, busy, nib_valid, nib_data, done, the index counter, the settle counter and the nibble counter. Reset mid-sweep or mid-stream abandons the operation; no partial data is retained.
- State IDLE, on start=1:
  - tt<=0, weight<=0, idx<=0, x_out<=0, wcnt<=0, busy<=1.
  - Go to SWEEP.
- State SWEEP, each cycle:
  - If wcnt==SETTLE: tt[idx]<=f_in; weight<=weight+f_in; wcnt<=0.
    - If idx==127: go to STREAM with nib counter k<=0.
    - Else: idx<=idx+1 and x_out<=idx+1.
  - Otherwise: wcnt<=wcnt+1.
  - Each vector is held SETTLE+1 cycles. f_in is sampled at the final edge of that window.
  - The full sweep takes 128*(SETTLE+1) cycles.
- State STREAM:
  - nib_valid=1 and nib_data=tt[127-4k -: 4], so the first nibble is tt[127:124].
  - On nib_valid&&nib_ready: k<=k+1.
  - When k==31 is accepted: nib_valid<=0, busy<=0, done<=1 for one cycle, go to IDLE.
  - nib_data is held stable while nib_valid&&!nib_ready.
- Holds between runs: x_out holds 127 after the sweep. tt and weight hold their values until the next start is accepted or reset.
- start while busy is ignored (no restart, no queueing). A start in the same cycle as done is ignored; IDLE is entered on that edge.
- weight is 8 bits wide so that the value 128 does not overflow.

Test Plan:
- f_in tied 0, SETTLE=1 -> tt=0, weight=0. Exactly 32 nibbles of 0x0, then done. busy high 256+32 cycles with nib_ready=1.
- f_in=x_out[0] -> tt=0xAAAA…AA (32×'A'), weight=64.
- f_in=x_out[6] -> first 16 nibbles 0xF, last 16 nibbles 0x0, weight=64. f_in=1 -> 32×0xF, weight=128.
- f_in=maj(x0,x1,x5), SETTLE=0 -> weight=64, tt[7]=1, tt[3]=1, tt[1]=0. Sweep takes exactly 128 cycles.
- nib_ready toggled randomly (~50%) -> nibble sequence identical to the always-ready run, with nib_data stable during stalls. A start pulse mid-stream is ignored.
- rst asserted at idx=60 -> all outputs 0 immediately. A subsequent start produces the correct full table.
